// File: rtl/modsubred_sched.sv
// Round-robin scheduler sharing one pipelined modsubred datapath among NREQ requesters, optional checker under MODSUBRED_SCHED_CHK_EN.
// Latency: accept at T -> issue at T+1 -> result written at T+1+LAT -> o_rsp_vld at T+2+LAT.
// Backpressure: per-requester credits (in-flight + FIFO occupancy) drop a requester's grant at DEPTH; the datapath never stalls.
module modsubred_sched #(
  parameter int NREQ  = 2,
  parameter int LAT   = 2,   // must match `COMMON_MODSUBRED_DELAY of the shared instance
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      i_req_vld,
  output logic [NREQ-1:0]      o_req_rdy,
  input  logic [39*NREQ-1:0]   i_req_din_0,
  input  logic [39*NREQ-1:0]   i_req_din_1,
  output logic                 o_sub_vld,
  output logic [38:0]          o_sub_din_0,
  output logic [38:0]          o_sub_din_1,
  input  logic                 i_sub_vldout,
  input  logic [34:0]          i_sub_dout,
  output logic [NREQ-1:0]      o_rsp_vld,
  input  logic [NREQ-1:0]      i_rsp_rdy,
  output logic [35*NREQ-1:0]   o_rsp_dout,
  output logic                 o_err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

`ifdef MODSUBRED_SCHED_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic [IW-1:0]  rr_ptr;
  logic [CW-1:0]  cnt [NREQ];
  logic [NREQ-1:0] elig, grant, pop, push, full;
  logic           acc;
  logic [IW-1:0]  gidx;

  logic           tag_vld [LAT+1];
  logic [IW-1:0]  tag_idx [LAT+1];

  logic [34:0]    mem [NREQ][DEPTH];
  logic [CW-1:0]  wp [NREQ];
  logic [CW-1:0]  rp [NREQ];

  // Eligibility and round-robin search starting just after the last winner
  always_comb begin
    elig  = '0;
    acc   = 1'b0;
    gidx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      elig[k] = i_req_vld[k] && (cnt[k] < CW'(DEPTH));
    end
    for (int i = 1; i <= NREQ; i++) begin
      if (!acc && elig[(int'(rr_ptr) + i) % NREQ]) begin
        acc  = 1'b1;
        gidx = IW'((int'(rr_ptr) + i) % NREQ);
      end
    end
    grant = acc ? (NREQ'(1) << gidx) : '0;
  end

  assign o_req_rdy = grant;

  // Register the winning operands toward the datapath and advance the pointer on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_sub_vld   <= 1'b0;
      o_sub_din_0 <= '0;
      o_sub_din_1 <= '0;
      rr_ptr      <= IW'(NREQ - 1);
    end else begin
      o_sub_vld   <= acc;
      o_sub_din_0 <= acc ? i_req_din_0[gidx*39 +: 39] : '0;
      o_sub_din_1 <= acc ? i_req_din_1[gidx*39 +: 39] : '0;
      if (acc) rr_ptr <= gidx;
    end
  end

  // Owner tag follows each op through the datapath; the tail lines up with i_sub_vldout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= LAT; i++) begin
        tag_vld[i] <= 1'b0;
        tag_idx[i] <= '0;
      end
    end else begin
      tag_vld[0] <= acc;
      tag_idx[0] <= gidx;
      for (int i = 1; i <= LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  end

  // FIFO status, result routing and the per-requester head outputs
  always_comb begin
    full       = '0;
    push       = '0;
    o_rsp_vld  = '0;
    o_rsp_dout = '0;
    for (int k = 0; k < NREQ; k++) begin
      full[k]      = (wp[k] - rp[k]) == CW'(DEPTH);
      push[k]      = i_sub_vldout && (tag_idx[LAT] == IW'(k)) && !(CHK_EN && full[k]);
      o_rsp_vld[k] = (wp[k] != rp[k]);
      if (o_rsp_vld[k]) o_rsp_dout[k*35 +: 35] = mem[k][rp[k][AW-1:0]];
    end
  end

  assign pop = o_rsp_vld & i_rsp_rdy;

  // Response storage, written at the pointer slot
  always_ff @(posedge clk) begin
    for (int k = 0; k < NREQ; k++) begin
      if (push[k]) mem[k][wp[k][AW-1:0]] <= i_sub_dout;
    end
  end

  // FIFO pointers and credit counters; accept and pop in one cycle cancel out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREQ; k++) begin
        wp[k]  <= '0;
        rp[k]  <= '0;
        cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (push[k]) wp[k] <= wp[k] + CW'(1);
        if (pop[k])  rp[k] <= rp[k] + CW'(1);
        case ({grant[k], pop[k]})
          2'b10:   cnt[k] <= cnt[k] + CW'(1);
          2'b01:   cnt[k] <= cnt[k] - CW'(1);
          default: cnt[k] <= cnt[k];
        endcase
      end
    end
  end

`ifdef MODSUBRED_SCHED_CHK_EN
  logic err_q;
  // Sticky flag: result valid out of step with the tag pipe, or a write into a full FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_q | (i_sub_vldout != tag_vld[LAT]) |
                         (i_sub_vldout && full[tag_idx[LAT]]);
  end
  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_modsubred_sched.sv
// Bench for modsubred_sched: directed scenarios plus random traffic against a queue-based scoreboard.
// The shared datapath is modelled here as a LAT-cycle delay computing (din_0 - din_1) mod 2^35.
// Requesters and response sinks are driven on the falling edge; the scoreboard judges each cycle.
module tb_modsubred_sched;
  localparam int NREQ  = 2;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int DW    = 39 * NREQ;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   i_req_vld = '0;
  logic [NREQ-1:0]   o_req_rdy;
  logic [DW-1:0]     i_req_din_0 = '0;
  logic [DW-1:0]     i_req_din_1 = '0;
  logic              o_sub_vld;
  logic [38:0]       o_sub_din_0, o_sub_din_1;
  logic              i_sub_vldout = 1'b0;
  logic [34:0]       i_sub_dout = '0;
  logic [NREQ-1:0]   o_rsp_vld;
  logic [NREQ-1:0]   i_rsp_rdy = '0;
  logic [35*NREQ-1:0] o_rsp_dout;
  logic              o_err;

  always #5 clk = ~clk;

  modsubred_sched #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_vld(i_req_vld), .o_req_rdy(o_req_rdy),
    .i_req_din_0(i_req_din_0), .i_req_din_1(i_req_din_1),
    .o_sub_vld(o_sub_vld), .o_sub_din_0(o_sub_din_0), .o_sub_din_1(o_sub_din_1),
    .i_sub_vldout(i_sub_vldout), .i_sub_dout(i_sub_dout),
    .o_rsp_vld(o_rsp_vld), .i_rsp_rdy(i_rsp_rdy), .o_rsp_dout(o_rsp_dout),
    .o_err(o_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Stimulus shadows, applied on the falling edge
  logic [NREQ-1:0] s_vld = '0;
  logic [NREQ-1:0] s_rsp_rdy = '0;
  logic [DW-1:0]   s_d0 = '0;
  logic [DW-1:0]   s_d1 = '0;
  logic            s_inj = 1'b0;
  bit              mon_en = 1'b1;

  // Reference state
  logic [34:0] exp_q [NREQ][$];
  logic [34:0] cap1 [$];
  int          mptr;
  logic        exp_sv;
  logic [38:0] exp_d0, exp_d1;
  int          grants [NREQ];
  logic        dpv [$];
  logic [34:0] dpd [$];

  task automatic model_reset();
    for (int k = 0; k < NREQ; k++) exp_q[k].delete();
    mptr   = NREQ - 1;
    exp_sv = 1'b0;
    exp_d0 = '0;
    exp_d1 = '0;
    dpv.delete();
    dpd.delete();
    for (int i = 0; i < LAT; i++) begin
      dpv.push_back(1'b0);
      dpd.push_back('0);
    end
    i_sub_vldout = 1'b0;
    i_sub_dout   = '0;
  endtask

  task automatic monitor();
    logic [NREQ-1:0] eg;
    int k;
    chk("sub_vld", 64'(o_sub_vld), 64'(exp_sv));
    chk("sub_din_0", 64'(o_sub_din_0), 64'(exp_d0));
    chk("sub_din_1", 64'(o_sub_din_1), 64'(exp_d1));
    eg = '0;
    for (int i = 1; i <= NREQ; i++) begin
      k = (mptr + i) % NREQ;
      if (eg == '0 && s_vld[k] && exp_q[k].size() < DEPTH) eg[k] = 1'b1;
    end
    chk("req_rdy", 64'(o_req_rdy), 64'(eg));
    for (int j = 0; j < NREQ; j++) begin
      if (o_rsp_vld[j] && s_rsp_rdy[j]) begin
        if (exp_q[j].size() == 0) chk("stale_rsp", 64'(o_rsp_vld[j]), 64'(0));
        else chk("rsp_dat", 64'(o_rsp_dout[j*35 +: 35]), 64'(exp_q[j].pop_front()));
        if (j == 1) cap1.push_back(o_rsp_dout[35 +: 35]);
      end
    end
    exp_sv = 1'b0;
    exp_d0 = '0;
    exp_d1 = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (o_req_rdy[j] && s_vld[j]) begin
        exp_q[j].push_back(35'(s_d0[j*39 +: 39] - s_d1[j*39 +: 39]));
        mptr   = j;
        exp_sv = 1'b1;
        exp_d0 = s_d0[j*39 +: 39];
        exp_d1 = s_d1[j*39 +: 39];
        grants[j]++;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      dpv.push_back(o_sub_vld);
      dpd.push_back(35'(o_sub_din_0 - o_sub_din_1));
      i_sub_vldout = dpv.pop_front() | s_inj;
      i_sub_dout   = dpd.pop_front();
    end else begin
      i_sub_vldout = 1'b0;
    end
    i_req_vld   = s_vld;
    i_rsp_rdy   = s_rsp_rdy;
    i_req_din_0 = s_d0;
    i_req_din_1 = s_d1;
    #1;
    if (rst_n && mon_en) monitor();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy"}, 64'(o_req_rdy), 64'(0));
    chk({tag, "_sub_vld"}, 64'(o_sub_vld), 64'(0));
    chk({tag, "_sub_din"}, 64'({o_sub_din_0, o_sub_din_1}), 64'(0));
    chk({tag, "_rsp_vld"}, 64'(o_rsp_vld), 64'(0));
    chk({tag, "_rsp_dout"}, 64'(o_rsp_dout), 64'(0));
    chk({tag, "_err"}, 64'(o_err), 64'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic rand_ops();
    s_d0 = DW'({$urandom(), $urandom(), $urandom()});
    s_d1 = DW'({$urandom(), $urandom(), $urandom()});
  endtask

  task automatic clear_grants();
    for (int k = 0; k < NREQ; k++) grants[k] = 0;
  endtask

  initial begin
    int pulses;
    model_reset();
    clear_grants();
    do_reset();
    tick();
    chk_all_zero("reset");

    // Single op: 10 - 3 from requester 0
    s_rsp_rdy = '1;
    s_vld = 2'b01;
    s_d0 = '0; s_d1 = '0;
    s_d0[38:0] = 39'd10;
    s_d1[38:0] = 39'd3;
    tick();
    chk("single_grant", 64'(o_req_rdy), 64'(1));
    s_vld = '0; s_d0 = '0; s_d1 = '0;
    tick();
    chk("single_issue_vld", 64'(o_sub_vld), 64'(1));
    chk("single_issue_d0", 64'(o_sub_din_0), 64'(10));
    chk("single_issue_d1", 64'(o_sub_din_1), 64'(3));
    tick();
    tick();
    chk("single_not_early", 64'(o_rsp_vld), 64'(0));
    tick();
    chk("single_rsp_vld", 64'(o_rsp_vld), 64'(1));
    chk("single_rsp_dat", 64'(o_rsp_dout[34:0]), 64'(7));
    repeat (4) tick();

    // Fairness: both requesters valid for 8 cycles
    clear_grants();
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      s_vld = (i < 8) ? 2'b11 : 2'b00;
      rand_ops();
      tick();
      if (i > 0 && o_sub_vld) pulses++;
    end
    chk("fair_pulses", 64'(pulses), 64'(8));
    chk("fair_g0", 64'(grants[0]), 64'(4));
    chk("fair_g1", 64'(grants[1]), 64'(4));
    s_vld = '0;
    repeat (8) tick();

    // Backpressure on requester 1
    clear_grants();
    s_rsp_rdy = 2'b01;
    s_vld = 2'b11;
    for (int i = 0; i < 20; i++) begin rand_ops(); tick(); end
    chk("bp_g1_capped", 64'(grants[1]), 64'(4));
    chk("bp_rdy1_low", 64'(o_req_rdy[1]), 64'(0));
    s_rsp_rdy = 2'b11;
    for (int i = 0; i < 12; i++) begin rand_ops(); tick(); end
    chk("bp_reenable", 64'(grants[1] > 4), 64'(1));
    s_vld = '0;
    repeat (10) tick();

    // Ordering for requester 1
    cap1.delete();
    s_vld = 2'b10;
    for (int j = 0; j < 4; j++) begin
      s_d0 = '0; s_d1 = '0;
      s_d0[39 +: 39] = 39'(100 + j);
      tick();
    end
    s_vld = '0;
    repeat (8) tick();
    chk("order_count", 64'(cap1.size()), 64'(4));
    for (int j = 0; j < 4 && j < cap1.size(); j++) chk("order_val", 64'(cap1[j]), 64'(100 + j));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      s_vld = NREQ'($urandom());
      s_rsp_rdy = NREQ'($urandom()) | NREQ'($urandom());
      rand_ops();
      tick();
    end
    s_vld = '0;
    s_rsp_rdy = '1;
    repeat (20) tick();
    for (int k = 0; k < NREQ; k++) chk("rand_drained", 64'(exp_q[k].size()), 64'(0));

    // Reset with ops in flight
    s_vld = 2'b11;
    rand_ops();
    tick();
    tick();
    s_vld = '0;
    tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all_zero("midrst");
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("midrst_no_stale", 64'(o_rsp_vld), 64'(0));
    end
    clear_grants();
    s_rsp_rdy = 2'b10;
    s_vld = 2'b01;
    for (int i = 0; i < 8; i++) begin rand_ops(); tick(); end
    chk("midrst_credit_zero", 64'(grants[0]), 64'(4));
    s_vld = '0;
    s_rsp_rdy = '1;
    repeat (8) tick();

`ifdef MODSUBRED_SCHED_CHK_EN
    chk("chk_err_idle", 64'(o_err), 64'(0));
    mon_en = 1'b0;
    s_rsp_rdy = '0;
    s_inj = 1'b1;
    tick();
    s_inj = 1'b0;
    tick();
    chk("chk_err_set", 64'(o_err), 64'(1));
    repeat (3) tick();
    chk("chk_err_held", 64'(o_err), 64'(1));
    do_reset();
    #1;
    chk("chk_err_cleared", 64'(o_err), 64'(0));
    mon_en = 1'b1;
    s_rsp_rdy = '1;
    repeat (4) tick();
`else
    chk("err_tied_low", 64'(o_err), 64'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/modsubred_sched.md
Name: modsubred_sched

Overview:
Round-robin scheduler that shares one pipelined modsubred datapath (fixed latency LAT) between NREQ requesters. It accepts operand pairs over valid/ready and issues at most one operation per cycle. A tag shift register tracks which requester owns each in-flight operation, and each result is routed back into that requester's response FIFO. Per-requester credits keep the non-stallable datapath from overflowing a FIFO. The block sits between the NTT/key-switch lane controllers and the shared modsubred instance.

Parameters:
NREQ, 2, number of requesters (2..8)
LAT, 2, datapath latency in cycles; equals `COMMON_MODSUBRED_DELAY
DEPTH, 4, response FIFO entries per requester (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
i_req_vld  in  NREQ  per-requester request valid
o_req_rdy  out  NREQ  per-requester request ready (grant)
i_req_din_0  in  39*NREQ  minuend; requester k uses bits [39k+38:39k]
i_req_din_1  in  39*NREQ  subtrahend; same packing
o_sub_vld  out  1  issue valid to datapath
o_sub_din_0  out  39  issued minuend
o_sub_din_1  out  39  issued subtrahend
i_sub_vldout  in  1  datapath result valid
i_sub_dout  in  35  datapath result
o_rsp_vld  out  NREQ  response valid per requester
i_rsp_rdy  in  NREQ  response ready per requester
o_rsp_dout  out  35*NREQ  response data; same packing at 35 bits
o_err  out  1  sticky protocol error (optional feature)

Behaviour:
- Reset values: o_req_rdy=0, o_sub_vld=0, o_sub_din_0/1=0, o_rsp_vld=0, o_rsp_dout=0, o_err=0; all FIFOs empty, credits=0, tag pipe cleared, RR pointer=NREQ-1 (requester 0 has priority first).
- Eligibility: requester k is eligible when i_req_vld[k]=1 and cnt[k] < DEPTH. cnt[k] = in-flight ops for k + FIFO[k] occupancy.
- Arbitration: combinational round-robin search starting at pointer+1 (mod NREQ). At most one bit of o_req_rdy is set, and only for an eligible requester. o_req_rdy depends on i_req_vld in the same cycle. The pointer updates to the granted index only on accept (vld&rdy).
- Issue: accept at cycle T registers o_sub_vld=1 and the operands at T+1. With no accept, o_sub_vld=0 and operands are 0.
- Tag pipe: valid+index shift register, depth LAT+1, loaded at accept. Its tail aligns with i_sub_vldout at T+1+LAT.
- Return: on i_sub_vldout, i_sub_dout is written into FIFO[tag index] at T+1+LAT. o_rsp_vld rises at T+2+LAT (registered FIFO output). Round-trip latency from accept to response is LAT+2.
- Credits: cnt[k] increments on accept for k and decrements on pop (o_rsp_vld[k]&i_rsp_rdy[k]). When both happen in the same cycle, cnt[k] is unchanged. Credits guarantee a FIFO write never finds the FIFO full.
- FIFO: read/write pointers are log2(DEPTH)+1 bits and wrap naturally. Simultaneous push and pop on a full FIFO is legal; occupancy stays the same. Ordering per requester is preserved.
- No stalls: the datapath is never back-pressured. A requester whose i_rsp_rdy is held low loses eligibility after DEPTH outstanding ops and does not block other requesters.
- Reset mid-operation: all in-flight tags and FIFO contents are discarded. The datapath must be reset by the same rst_n.

Optional Feature:
MODSUBRED_SCHED_CHK_EN
- Defined: o_err is set and held until reset when either (a) i_sub_vldout differs from the tag-pipe tail valid, or (b) a FIFO write targets a full FIFO. On (b) the data is dropped.
- Undefined: checker logic is absent and o_err is tied to 0.

Test Plan:
- Single op: req0 sends din_0=10, din_1=3 at T -> o_sub_vld=1 with 10/3 at T+1. A model returning dout=7 at T+3 -> o_rsp_vld[0]=1, dout=7 at T+4.
- Fairness: both requesters hold valid for 8 cycles with rsp_rdy=1 -> grants alternate 0,1,0,1..., 4 each, with 8 consecutive o_sub_vld pulses.
- Backpressure: i_rsp_rdy[1]=0, both valid -> after 4 accepts for req1, o_req_rdy[1] stays 0 and req0 takes every grant. Raising rsp_rdy[1] drains results in order and re-enables req1.
- Per-requester ordering: req1 sends 4 ops with din_0=100..103, din_1=0 -> responses 100,101,102,103 in that order.
- Reset mid-flight: rst_n=0 with 2 ops in flight -> all outputs 0 immediately. After release, cnt=0 and no stale responses appear.
- Checker (CHK_EN): inject i_sub_vldout=1 with an empty tag pipe -> o_err=1 next cycle, held until reset.
